// File: rtl/inv_sub_bytes_if.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_if
//   Handshake bundle for the inv_sub_bytes engine.
//   master : upstream/downstream side (drives in_valid, in_state, out_ready)
//   slave  : the engine itself       (drives in_ready, out_valid, out_state, busy)
//   Signals:
//     in_valid / in_ready / in_state    input state handshake (128-bit state)
//     out_valid / out_ready / out_state result handshake (128-bit state)
//     busy                              engine is in RUN or DONE
//     fwd                               forward S-box select, only when
//                                       SBOX_FWD_EN is defined
// ---------------------------------------------------------------------------
interface inv_sub_bytes_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
`ifdef SBOX_FWD_EN
  logic         fwd;

  modport master (
    output in_valid, in_state, out_ready, fwd,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready, fwd,
    output in_ready, out_valid, out_state, busy
  );
`else
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
`endif
endinterface

// File: rtl/inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes
//   AES InvSubBytes engine. Accepts a 128-bit state, replaces every byte with
//   its inverse S-box value, BPC bytes per clock, and returns the result over
//   a valid/ready handshake. The S-box is computed arithmetically: inverse
//   affine transform followed by a GF(2^8) inverse (t^254), no lookup table.
//
//   Parameters:
//     BPC        bytes substituted per cycle (1,2,4,8,16); G = 16/BPC groups
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high reset
//     bus        inv_sub_bytes_if.slave (in/out handshakes, busy, fwd)
//   Optional feature (macro SBOX_FWD_EN):
//     adds bus.fwd, latched at accept; fwd=1 applies the forward S-box,
//     fwd=0 the inverse. Without the macro the block always applies InvS.
//     Both modes share one GF(2^8) inverse core per lane.
//   Byte order: byte i = state[127-8i -: 8], byte 0 is the MSB.
// ---------------------------------------------------------------------------
module inv_sub_bytes #(
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         reset,
  inv_sub_bytes_if.slave bus
);

  localparam int G  = 16 / BPC;
  localparam int CW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // -------------------------------------------------------------------------
  // GF(2^8) arithmetic, polynomial 0x11B. XOR-only, 8-bit throughout.
  // -------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // t^254 via an addition chain; 0 maps to 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] t);
    logic [7:0] t3, t7, t15, t31, t63, t127;
    t3   = gf_mul(gf_mul(t, t), t);
    t7   = gf_mul(gf_mul(t3, t3), t);
    t15  = gf_mul(gf_mul(t7, t7), t);
    t31  = gf_mul(gf_mul(t15, t15), t);
    t63  = gf_mul(gf_mul(t31, t31), t);
    t127 = gf_mul(gf_mul(t63, t63), t);
    return gf_mul(t127, t127);
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // One lane: the GF inverse sits between two muxes so both directions share it.
  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic fwd);
    logic [7:0] x;
    logic [7:0] y;
    x = fwd ? b : inv_affine(b);
    y = gf_inv(x);
    return fwd ? fwd_affine(y) : y;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  state_q, state_d;
  logic [127:0]  work;
  int            idx;
  logic          mode_fwd;

`ifdef SBOX_FWD_EN
  logic fwd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_q <= 1'b0;
    end else if (fsm_q == IDLE && bus.in_valid) begin
      fwd_q <= bus.fwd;
    end
  end

  assign mode_fwd = fwd_q;
`else
  assign mode_fwd = 1'b0;
`endif

  // NOTE: the 128-bit state register is reset too, because out_state is
  // architecturally visible at all times and must read zero after reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Substituted copy of the current group; bytes outside the group pass through.
  // NOTE: every variable written in a combinational block gets a default
  // first, otherwise paths that skip an assignment would infer latches.
  always_comb begin
    work = state_q;
    idx  = 0;
    for (int k = 0; k < BPC; k++) begin
      idx = int'(cnt_q) * BPC + k;
      work[127 - 8*idx -: 8] = sub_byte(state_q[127 - 8*idx -: 8], mode_fwd);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          fsm_d   = RUN;
          cnt_d   = '0;
          state_d = bus.in_state;
        end
      end
      RUN: begin
        state_d = work;
        if (cnt_q == CW'(G - 1)) begin
          fsm_d = DONE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.busy      = (fsm_q != IDLE);
  assign bus.out_state = state_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// tb_inv_sub_bytes
//   Directed bench for inv_sub_bytes. Two instances: BPC=1 (main) and BPC=16
//   (single-cycle latency). Expected values are hand-computed AES constants
//   or come from a bench-side S-box model built by exhaustive GF search.
// ---------------------------------------------------------------------------
module tb_inv_sub_bytes;

  logic clk;
  logic reset;

  inv_sub_bytes_if bus ();
  inv_sub_bytes_if bus16 ();

  inv_sub_bytes #(.BPC(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  inv_sub_bytes #(.BPC(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  localparam logic [127:0] VEC_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] VEC_OUT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ZERO_IN = 128'h0;
  localparam logic [127:0] ZERO_OUT= {16{8'h52}};
  localparam logic [127:0] S16_IN  = {16{8'h16}};
  localparam logic [127:0] S16_OUT = {16{8'hff}};
  localparam logic [127:0] ED_IN   = 128'hed000000000000000000000000000000;
  localparam logic [127:0] ED_OUT  = 128'h53525252525252525252525252525252;

  int   total;
  int   bad;
  logic fwd_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SBOX_FWD_EN
  assign bus.fwd   = fwd_drv;
  assign bus16.fwd = 1'b0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference S-box: GF inverse found by search, then forward affine.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (b != 8'h00 && ref_mul(b, 8'(y)) == 8'h01) inv = 8'(y);
    s = 8'h63;
    for (int r = 0; r < 5; r++)
      s = s ^ ((inv << r) | (inv >> (8 - r)));
    return s;
  endfunction

  // Called at a negedge; returns at a negedge after the result is released.
  task automatic do_op(input logic [127:0] din, input logic fsel,
                       output logic [127:0] dout, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) check("rdy_timeout", 128'(bus.in_ready), 128'd1);
    fwd_drv      = fsel;
    bus.in_valid = 1'b1;
    bus.in_state = din;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_state = '0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    dout = bus.out_state;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  logic [127:0] res;
  logic [127:0] din;
  logic [127:0] dexp;
  int           lat;

  initial begin
    total = 0;
    bad   = 0;
    fwd_drv = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_state    = '0;
    bus.out_ready   = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.in_state  = '0;
    bus16.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_in_ready",  128'(bus.in_ready),  128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_state", bus.out_state,       128'd0);
    check("rst_busy",      128'(bus.busy),      128'd0);

    // Main vector and latency
    do_op(VEC_IN, 1'b0, res, lat);
    check("vec_result", res, VEC_OUT);
    check("vec_latency", 128'(lat), 128'd16);
    check("vec_idle_after", 128'(bus.in_ready), 128'd1);

    // Boundary vectors
    do_op(ZERO_IN, 1'b0, res, lat);
    check("zero_state", res, ZERO_OUT);
    do_op(S16_IN, 1'b0, res, lat);
    check("all16_state", res, S16_OUT);
    do_op(ED_IN, 1'b0, res, lat);
    check("byte_ed", res, ED_OUT);

    // Backpressure: hold DONE for 10 cycles
    bus.in_valid = 1'b1;
    bus.in_state = VEC_IN;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 128'(lat), 128'd16);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_state", bus.out_state, VEC_OUT);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_valid", 128'(bus.out_valid), 128'd0);
    check("bp_release_ready", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.in_state = S16_IN;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_new_accept", 128'(bus.busy), 128'd1);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_new_result", bus.out_state, S16_OUT);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Abort at cnt=7 with a mid-cycle reset
    bus.in_valid = 1'b1;
    bus.in_state = VEC_IN;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_in_ready",  128'(bus.in_ready),  128'd1);
    check("abort_out_valid", 128'(bus.out_valid), 128'd0);
    check("abort_out_state", bus.out_state,       128'd0);
    check("abort_busy",      128'(bus.busy),      128'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(ZERO_IN, 1'b0, res, lat);
    check("abort_next_result", res, ZERO_OUT);
    check("abort_next_latency", 128'(lat), 128'd16);

    // BPC=16 instance: one-edge latency
    bus16.in_valid = 1'b1;
    bus16.in_state = VEC_IN;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bpc16_latency", 128'(lat), 128'd1);
    check("bpc16_result", bus16.out_state, VEC_OUT);
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
    check("bpc16_idle", 128'(bus16.in_ready), 128'd1);

    // Sweep: InvS(S(b)) == b over all 256 values, 16 bytes per operation
    for (int j = 0; j < 16; j++) begin
      din  = '0;
      dexp = '0;
      for (int k = 0; k < 16; k++) begin
        din[127 - 8*k -: 8]  = ref_sbox(8'(16*j + k));
        dexp[127 - 8*k -: 8] = 8'(16*j + k);
      end
      do_op(din, 1'b0, res, lat);
      check($sformatf("sweep_inv_%0d", j), res, dexp);
    end

`ifdef SBOX_FWD_EN
    do_op(VEC_OUT, 1'b1, res, lat);
    check("fwd_vector", res, VEC_IN);
    check("fwd_latency", 128'(lat), 128'd16);
    for (int j = 0; j < 16; j++) begin
      din  = '0;
      dexp = '0;
      for (int k = 0; k < 16; k++) begin
        din[127 - 8*k -: 8]  = 8'(16*j + k);
        dexp[127 - 8*k -: 8] = ref_sbox(8'(16*j + k));
      end
      do_op(din, 1'b1, res, lat);
      check($sformatf("sweep_fwd_%0d", j), res, dexp);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
